// File: rtl/sim_mon_pkg.sv
// Shared types and constants for the run monitor: FSM states, cycle-counter width,
// and the one-hot verdict codes decoded from the terminal state.
package sim_mon_pkg;

   localparam int CYC_W = 32;

   typedef enum logic [2:0] {
      S_RUN,
      S_D_PASS,
      S_D_FAIL,
      S_D_HALT,
      S_D_TOUT
   } state_e;

   // Verdict bit order is {timed_out, halted, fail, pass}
   localparam logic [3:0] V_NONE = 4'b0000;
   localparam logic [3:0] V_PASS = 4'b0001;
   localparam logic [3:0] V_FAIL = 4'b0010;
   localparam logic [3:0] V_HALT = 4'b0100;
   localparam logic [3:0] V_TOUT = 4'b1000;

   function automatic logic [3:0] verdict_of(input state_e s);
      case (s)
         S_D_PASS: return V_PASS;
         S_D_FAIL: return V_FAIL;
         S_D_HALT: return V_HALT;
         S_D_TOUT: return V_TOUT;
         default:  return V_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sim_mon_log_fifo.sv
// Show-ahead synchronous FIFO for the store log. Writes are dropped when full
// unless a pop happens in the same cycle; pops on empty are ignored.
module sim_mon_log_fifo #(
   parameter int DW    = 128,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_req,
   input  logic                       pop_req,
   input  logic [DW-1:0]              wdata,
   output logic [DW-1:0]              rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          push, pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign pop   = pop_req && !empty;
   assign push  = push_req && (!full || pop);
   // Head is forced to zero when empty so stale entries never leak after reset
   assign rdata = empty ? '0 : mem[rp];

   always_ff @(posedge clk) begin
      if (reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= wdata;
   end

endmodule

// File: rtl/sim_run_monitor.sv
// Run monitor for the multi-cycle core: detects halt, watchdog timeout and a
// pass/fail verdict store, and logs every store made while running.
module sim_run_monitor
   import sim_mon_pkg::*;
#(
   parameter int               WIDTH          = 64,
   parameter int               TIMEOUT_CYCLES = 200,
   parameter int               ARM_DELAY      = 2,
   parameter int               HALT_REPEAT    = 1,
   parameter int               LOG_DEPTH      = 16,
   parameter logic [WIDTH-1:0] CHECK_ADDR     = 'd84,
   parameter logic [WIDTH-1:0] CHECK_DATA     = 'd7
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [WIDTH-1:0]            instr,
   input  logic [WIDTH-1:0]            memaddr,
   input  logic [WIDTH-1:0]            writedata,
   input  logic                        memwrite,
   input  logic                        log_rd_en,
   output logic                        log_valid,
   output logic [WIDTH-1:0]            log_addr,
   output logic [WIDTH-1:0]            log_data,
   output logic [$clog2(LOG_DEPTH):0]  log_count,
   output logic                        log_ovf,
   output logic [31:0]                 cycles,
   output logic                        done,
   output logic                        halted,
   output logic                        timed_out,
   output logic                        pass,
   output logic                        fail
);

   state_e           state, state_nx;
   logic [CYC_W-1:0] zrun, zrun_nx;
   logic             run, armed, zero_instr, chk_hit, halt_hit, tout_hit;
   logic             push, drop, log_full, log_empty;
   logic [2*WIDTH-1:0] head;

   assign run        = (state == S_RUN);
   assign armed      = (cycles >= CYC_W'(ARM_DELAY));
   assign zero_instr = (instr == '0);
   assign chk_hit    = memwrite && (memaddr == CHECK_ADDR);
   assign tout_hit   = (cycles == CYC_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      zrun_nx  = '0;
      if (armed && zero_instr) zrun_nx = zrun + 1'b1;
      halt_hit = armed && zero_instr && (zrun_nx >= CYC_W'(HALT_REPEAT));
      state_nx = state;
      // Priority: verdict store, then halt, then watchdog
      if (run) begin
         if (chk_hit)       state_nx = (writedata == CHECK_DATA) ? S_D_PASS : S_D_FAIL;
         else if (halt_hit) state_nx = S_D_HALT;
         else if (tout_hit) state_nx = S_D_TOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_RUN;
         cycles  <= '0;
         zrun    <= '0;
         log_ovf <= 1'b0;
      end else begin
         state <= state_nx;
         if (run) begin
            zrun <= zrun_nx;
            if (cycles != '1) cycles <= cycles + 1'b1;
         end
         if (drop) log_ovf <= 1'b1;
      end
   end

   assign done = !run;
   assign {timed_out, halted, fail, pass} = verdict_of(state);

   assign push = run && memwrite;
   assign drop = push && log_full && !(log_rd_en && !log_empty);

   sim_mon_log_fifo #(
      .DW    (2*WIDTH),
      .DEPTH (LOG_DEPTH)
   ) u_log (
      .clk      (clk),
      .reset    (reset),
      .push_req (push),
      .pop_req  (log_rd_en),
      .wdata    ({memaddr, writedata}),
      .rdata    (head),
      .count    (log_count),
      .full     (log_full),
      .empty    (log_empty)
   );

   assign log_valid          = !log_empty;
   assign {log_addr, log_data} = head;

endmodule

// File: tb/tb_sim_run_monitor.sv
// Directed bench for sim_run_monitor: halt, pass, fail, priority, watchdog,
// store-log overflow/readout and mid-run reset.
module tb_sim_run_monitor;

   localparam int W  = 64;
   localparam int LD = 4;
   localparam int CW = $clog2(LD) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  instr = '0, memaddr = '0, writedata = '0;
   logic          memwrite = 1'b0, log_rd_en = 1'b0;
   logic          log_valid, log_ovf, done, halted, timed_out, pass, fail;
   logic [W-1:0]  log_addr, log_data;
   logic [CW-1:0] log_count;
   logic [31:0]   cycles;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   sim_run_monitor #(
      .WIDTH(W), .TIMEOUT_CYCLES(20), .ARM_DELAY(2), .HALT_REPEAT(1),
      .LOG_DEPTH(LD), .CHECK_ADDR('d84), .CHECK_DATA('d7)
   ) dut (
      .clk(clk), .reset(reset), .instr(instr), .memaddr(memaddr),
      .writedata(writedata), .memwrite(memwrite), .log_rd_en(log_rd_en),
      .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
      .log_count(log_count), .log_ovf(log_ovf), .cycles(cycles), .done(done),
      .halted(halted), .timed_out(timed_out), .pass(pass), .fail(fail)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [63:0] ins);
      reset = 1'b1; instr = ins; memwrite = 1'b0; log_rd_en = 1'b0;
      memaddr = '0; writedata = '0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic store(input logic [63:0] a, input logic [63:0] d, input logic pop);
      memaddr = a; writedata = d; memwrite = 1'b1; log_rd_en = pop;
      tick();
      memwrite = 1'b0; log_rd_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] ea [4];
      ea = '{64'd101, 64'd102, 64'd103, 64'd106};

      // Halt after arming; instr is zero from the first cycle
      do_reset('0);
      chk("rst_done", done, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_verdicts", {pass, fail, halted, timed_out}, 0);
      chk("rst_log", {log_valid, log_ovf, 3'(log_count)}, 0);
      chk("rst_head", log_addr, 0);
      repeat (2) tick();
      chk("halt_unarmed", halted, 0);
      chk("halt_cyc2", cycles, 2);
      tick();
      chk("halt_fired", {done, halted}, 2'b11);
      chk("halt_others", {pass, fail, timed_out}, 0);

      // Pass verdict store at cycle 10
      do_reset(64'h2008_0005);
      repeat (10) tick();
      chk("pass_pre", done, 0);
      store(84, 7, 1'b0);
      chk("pass_flag", {done, pass, fail, halted, timed_out}, 5'b11000);
      chk("pass_cycles", cycles, 11);
      chk("pass_count", log_count, 1);
      chk("pass_head", {log_addr, log_data}, {64'd84, 64'd7});
      tick();
      chk("pass_frozen", cycles, 11);
      log_rd_en = 1'b1; tick(); log_rd_en = 1'b0;
      chk("pass_pop", {log_valid, 3'(log_count)}, 0);
      chk("pass_sticky", pass, 1);

      // Fail verdict; near-miss addresses must not trigger
      do_reset(64'h2008_0005);
      store(80, 7, 1'b0);
      store(64'h1_0000_0054, 7, 1'b0);
      chk("fail_nomatch", done, 0);
      store(84, 5, 1'b0);
      chk("fail_flag", {done, pass, fail}, 3'b101);
      chk("fail_count", log_count, 3);

      // Verdict store beats halt in the same cycle
      do_reset(64'h2008_0005);
      repeat (3) tick();
      instr = '0;
      store(84, 7, 1'b0);
      chk("prio_pass", {pass, halted}, 2'b10);

      // Watchdog at pre-increment cycles == 19
      do_reset(64'h2008_0005);
      repeat (19) tick();
      chk("tout_pre", {timed_out, done}, 0);
      chk("tout_cyc19", cycles, 19);
      tick();
      chk("tout_fired", {timed_out, done, pass, fail, halted}, 5'b11000);
      chk("tout_cyc20", cycles, 20);
      tick();
      chk("tout_frozen", cycles, 20);

      // Log overflow, push+pop while full, ordered readout, push+pop while empty
      do_reset(64'h2008_0005);
      for (int i = 0; i < 6; i++) store(100 + i, 200 + i, 1'b0);
      chk("ovf_count", log_count, 4);
      chk("ovf_flag", {log_ovf, done}, 2'b10);
      chk("ovf_head", {log_addr, log_data}, {64'd100, 64'd200});
      store(106, 206, 1'b1);
      chk("full_pushpop_cnt", log_count, 4);
      for (int i = 0; i < 4; i++) begin
         chk("rd_addr", log_addr, ea[i]);
         chk("rd_data", log_data, ea[i] + 100);
         log_rd_en = 1'b1; tick(); log_rd_en = 1'b0;
      end
      chk("rd_empty", {log_valid, 3'(log_count)}, 0);
      store(107, 207, 1'b1);
      chk("empty_pushpop", {log_valid, 3'(log_count)}, 4'b1001);
      chk("empty_pp_head", log_addr, 107);

      // Reset mid-run clears log and counters
      do_reset(64'h2008_0005);
      for (int i = 0; i < 3; i++) store(300 + i, i, 1'b0);
      chk("mid_count", log_count, 3);
      reset = 1'b1; tick();
      chk("mid_rst_log", {log_valid, 3'(log_count)}, 0);
      chk("mid_rst_cyc", cycles, 0);
      chk("mid_rst_done", done, 0);
      reset = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
